// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: default stage widths, the IF/ID payload
// layout and the constant driven onto a bubble.
package pipe_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } if_id_payload_t;

  localparam int IF_ID_W = $bits(if_id_payload_t);

  localparam logic [IF_ID_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle around one pipeline-stage buffer: upstream
// side (in_*), downstream side (out_*) and the occupancy count.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;

  // slave = the stage buffer itself; master = the surrounding pipeline.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Buffered pipeline-stage register: DEPTH-entry in-order circular buffer
// with valid/ready on both sides, synchronous flush and optional zeroed bubbles.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W         = IF_ID_W,
  parameter int DEPTH          = 2,
  parameter int BYPASS_READY   = 0,
  parameter int ZERO_ON_BUBBLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_buf_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 1) begin : g_depth_chk
    $error("pipe_stage_buf: DEPTH must be >= 1");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // Explicit compare so non-power-of-2 depths wrap correctly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  // With BYPASS_READY a full buffer still accepts when the head leaves this cycle.
  assign bus.in_ready  = !full || ((BYPASS_READY != 0) && bus.out_ready);
  assign bus.out_valid = !empty;
  assign bus.count     = cnt;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    // NOTE: rst and flush take priority over any handshake in the same cycle.
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: payload storage is deliberately not reset; validity lives in cnt alone.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[wr_ptr] <= bus.in_data;
  end

  assign bus.out_data = ((ZERO_ON_BUBBLE != 0) && empty) ? DATA_W'(ZERO_WORD)
                                                         : mem[rd_ptr];

  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    cnt <= CNT_W'(DEPTH));

  a_push_needs_ready : assert property (@(posedge clk) disable iff (rst)
    push |-> bus.in_ready);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed and scoreboard-checked bench for pipe_stage_buf across four
// configurations (depth, ready bypass, bubble zeroing).
module tb_pipe_stage_buf;

  localparam logic [63:0] WA = 64'h1000_0013;
  localparam logic [63:0] WB = 64'h1004_0093;
  localparam logic [63:0] WC = 64'h1008_0113;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_buf_if #(.DATA_W(64), .DEPTH(2)) if_a ();
  pipe_stage_buf_if #(.DATA_W(64), .DEPTH(1)) if_b ();
  pipe_stage_buf_if #(.DATA_W(64), .DEPTH(3)) if_c ();
  pipe_stage_buf_if #(.DATA_W(64), .DEPTH(2)) if_d ();

  pipe_stage_buf #(.DATA_W(64), .DEPTH(2), .BYPASS_READY(0), .ZERO_ON_BUBBLE(1))
    u_a (.clk(clk), .rst(rst), .flush(flush), .bus(if_a));
  pipe_stage_buf #(.DATA_W(64), .DEPTH(1), .BYPASS_READY(1), .ZERO_ON_BUBBLE(1))
    u_b (.clk(clk), .rst(rst), .flush(flush), .bus(if_b));
  pipe_stage_buf #(.DATA_W(64), .DEPTH(3), .BYPASS_READY(1), .ZERO_ON_BUBBLE(1))
    u_c (.clk(clk), .rst(rst), .flush(flush), .bus(if_c));
  pipe_stage_buf #(.DATA_W(64), .DEPTH(2), .BYPASS_READY(0), .ZERO_ON_BUBBLE(0))
    u_d (.clk(clk), .rst(rst), .flush(flush), .bus(if_d));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic iv, input logic [63:0] d, input logic orr);
    if_a.in_valid  = iv;
    if_a.in_data   = d;
    if_a.out_ready = orr;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] q  [$];
    logic [63:0] qc [$];
    logic        iv, orr, fl, exp_rdy, exp_push, exp_pop, done;
    logic [63:0] dat;
    int          pushed;

    rst   = 1'b1;
    flush = 1'b0;
    drive_a(1'b1, WA, 1'b0);
    if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.out_ready = 1'b0;
    if_c.in_valid = 1'b0; if_c.in_data = '0; if_c.out_ready = 1'b0;
    if_d.in_valid = 1'b0; if_d.in_data = '0; if_d.out_ready = 1'b0;

    // Reset held three cycles with in_valid asserted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", if_a.out_valid, 1'b0);
    check("rst_count",     if_a.count,     '0);
    check("rst_in_ready",  if_a.in_ready,  1'b1);
    check("rst_out_data",  if_a.out_data,  '0);
    rst = 1'b0;
    drive_a(1'b0, '0, 1'b0);
    nxt();

    // Streaming with out_ready held high.
    drive_a(1'b1, WA, 1'b1);
    @(negedge clk);
    check("str0_out_valid", if_a.out_valid, 1'b0);
    check("str0_in_ready",  if_a.in_ready,  1'b1);
    nxt();
    drive_a(1'b1, WB, 1'b1);
    @(negedge clk);
    check("str1_out_data", if_a.out_data, WA);
    check("str1_count",    if_a.count,    2'd1);
    nxt();
    drive_a(1'b0, '0, 1'b1);
    @(negedge clk);
    check("str2_out_data", if_a.out_data, WB);
    check("str2_count",    if_a.count,    2'd1);
    nxt();
    @(negedge clk);
    check("str3_out_valid", if_a.out_valid, 1'b0);
    check("str3_out_data",  if_a.out_data,  '0);
    nxt();

    // Backpressure: third word held until space frees.
    drive_a(1'b1, WA, 1'b0);
    nxt();
    drive_a(1'b1, WB, 1'b0);
    @(negedge clk);
    check("bp1_count", if_a.count, 2'd1);
    nxt();
    drive_a(1'b1, WC, 1'b0);
    @(negedge clk);
    check("bp2_in_ready", if_a.in_ready, 1'b0);
    check("bp2_count",    if_a.count,    2'd2);
    check("bp2_out_data", if_a.out_data, WA);
    nxt();
    drive_a(1'b1, WC, 1'b1);
    @(negedge clk);
    check("bp3_count",    if_a.count,    2'd2);
    check("bp3_in_ready", if_a.in_ready, 1'b0);
    check("bp3_out_data", if_a.out_data, WA);
    nxt();
    @(negedge clk);
    check("bp4_out_data", if_a.out_data, WB);
    check("bp4_in_ready", if_a.in_ready, 1'b1);
    nxt();
    drive_a(1'b0, '0, 1'b1);
    @(negedge clk);
    check("bp5_out_data", if_a.out_data, WC);
    check("bp5_count",    if_a.count,    2'd1);
    nxt();
    @(negedge clk);
    check("bp6_out_valid", if_a.out_valid, 1'b0);
    nxt();

    // Flush with a same-cycle accepted push; the pushed word must vanish.
    drive_a(1'b1, 64'hD, 1'b0);
    nxt();
    drive_a(1'b1, 64'hF, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    check("fl_in_ready", if_a.in_ready, 1'b1);
    nxt();
    flush = 1'b0;
    drive_a(1'b0, '0, 1'b1);
    @(negedge clk);
    check("fl_out_valid", if_a.out_valid, 1'b0);
    check("fl_count",     if_a.count,     '0);
    nxt();
    drive_a(1'b1, 64'h6, 1'b1);
    @(negedge clk);
    check("fl2_out_valid", if_a.out_valid, 1'b0);
    nxt();
    drive_a(1'b0, '0, 1'b1);
    @(negedge clk);
    check("fl3_out_data", if_a.out_data, 64'h6);
    nxt();

    // ZERO_ON_BUBBLE=0: empty head shows slot 0 contents after pointers wrap.
    if_d.out_ready = 1'b0;
    if_d.in_valid = 1'b1; if_d.in_data = WA;
    nxt();
    if_d.in_data = WB;
    nxt();
    if_d.in_valid = 1'b0; if_d.out_ready = 1'b1;
    @(negedge clk);
    check("zob0_head_a", if_d.out_data, WA);
    nxt();
    @(negedge clk);
    check("zob0_head_b", if_d.out_data, WB);
    nxt();
    @(negedge clk);
    check("zob0_empty_valid", if_d.out_valid, 1'b0);
    check("zob0_stale_data",  if_d.out_data,  WA);
    if_d.out_ready = 1'b0;
    nxt();

    // DEPTH=1 with ready bypass: one word per cycle, in_ready stays high.
    if_b.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if_b.in_valid = (k < 5);
      if_b.in_data  = 64'hB0 + 64'(k);
      @(negedge clk);
      check("d1_in_ready",  if_b.in_ready,  1'b1);
      check("d1_out_valid", if_b.out_valid, (k != 0));
      check("d1_count",     if_b.count,     (k != 0));
      check("d1_out_data",  if_b.out_data,  (k != 0) ? 64'hB0 + 64'(k - 1) : 64'h0);
      nxt();
    end
    if_b.in_valid = 1'b0;
    @(negedge clk);
    check("d1_drained", if_b.out_valid, 1'b0);
    nxt();

    // DEPTH=3 with ready bypass: ten pushes, random out_ready, pointers wrap.
    pushed = 0;
    done   = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      orr = 1'($urandom_range(0, 1));
      iv  = (pushed < 10);
      dat = 64'hC000 + 64'(pushed);
      if_c.in_valid = iv; if_c.in_data = dat; if_c.out_ready = orr;
      @(negedge clk);
      exp_rdy = (qc.size() < 3) || orr;
      check("d3_in_ready",  if_c.in_ready,  exp_rdy);
      check("d3_out_valid", if_c.out_valid, (qc.size() != 0));
      check("d3_count",     if_c.count,     64'(qc.size()));
      check("d3_out_data",  if_c.out_data,  (qc.size() != 0) ? qc[0] : 64'h0);
      exp_push = iv && exp_rdy;
      exp_pop  = (qc.size() != 0) && orr;
      if (exp_pop)  void'(qc.pop_front());
      if (exp_push) begin
        qc.push_back(dat);
        pushed++;
      end
      nxt();
      if (pushed == 10 && qc.size() == 0) done = 1'b1;
    end
    check("d3_all_drained", done, 1'b1);

    // DEPTH=3 full, bypass push and flush in the same cycle.
    if_c.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if_c.in_valid = 1'b1; if_c.in_data = 64'hE0 + 64'(k);
      nxt();
    end
    if_c.in_data = 64'hEF; if_c.out_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("d3fl_count_full", if_c.count,    2'd3);
    check("d3fl_in_ready",   if_c.in_ready, 1'b1);
    nxt();
    flush = 1'b0;
    if_c.in_valid = 1'b0;
    @(negedge clk);
    check("d3fl_out_valid", if_c.out_valid, 1'b0);
    check("d3fl_count",     if_c.count,     '0);
    nxt();

    // Reset mid-operation drops everything.
    drive_a(1'b1, WA, 1'b0);
    nxt();
    drive_a(1'b1, WB, 1'b0);
    nxt();
    drive_a(1'b0, '0, 1'b0);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_count",     if_a.count,     '0);
    check("midrst_out_valid", if_a.out_valid, 1'b0);
    check("midrst_out_data",  if_a.out_data,  '0);
    nxt();

    // Random traffic on both DEPTH=2 variants against one queue model.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      iv  = ($urandom_range(0, 3) != 0);
      orr = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 31) == 0);
      dat = {$urandom, $urandom};
      drive_a(iv, dat, orr);
      if_d.in_valid = iv; if_d.in_data = dat; if_d.out_ready = orr;
      flush = fl;
      @(negedge clk);
      exp_rdy = (q.size() < 2);
      check("rnd_a_in_ready",  if_a.in_ready,  exp_rdy);
      check("rnd_a_out_valid", if_a.out_valid, (q.size() != 0));
      check("rnd_a_count",     if_a.count,     64'(q.size()));
      check("rnd_a_out_data",  if_a.out_data,  (q.size() != 0) ? q[0] : 64'h0);
      check("rnd_d_in_ready",  if_d.in_ready,  exp_rdy);
      check("rnd_d_out_valid", if_d.out_valid, (q.size() != 0));
      check("rnd_d_count",     if_d.count,     64'(q.size()));
      if (q.size() != 0) check("rnd_d_out_data", if_d.out_data, q[0]);
      exp_push = iv && exp_rdy;
      exp_pop  = (q.size() != 0) && orr;
      if (fl) begin
        q.delete();
      end else begin
        if (exp_pop)  void'(q.pop_front());
        if (exp_push) q.push_back(dat);
      end
      nxt();
    end
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
